// File: rtl/calculator_pkg.sv
// Shared types and default widths for the streaming calculator.
//   state_t : controller FSM states
//   op_t    : ALU operation select (matches the 2-bit op_i encoding)
//   DEF_*   : default parameter values used by the controller and ALU
package calculator_pkg;

  localparam int unsigned DEF_OP_W   = 32;
  localparam int unsigned DEF_MEM_W  = 64;
  localparam int unsigned DEF_LANES  = 2;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for the stream controller.
// Optional feature: define CALC_SAT_EN to make ADD/SUB saturate instead of wrap.
// Ports:
//   a_i, b_i    : operands (OP_W)
//   op_i        : operation (op_t)
//   result_c_o  : a op b, truncated (or saturated) to OP_W
//   flag_c_o    : ADD carry-out or SUB borrow; 0 for AND/XOR
module calc_alu
  import calculator_pkg::*;
#(
  parameter int unsigned OP_W = DEF_OP_W
) (
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  input  op_t             op_i,
  output logic [OP_W-1:0] result_c_o,
  output logic            flag_c_o
);

  logic [OP_W:0] sum;
  logic [OP_W:0] diff;

  // One extra bit captures carry (ADD) or borrow (SUB)
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    result_c_o = '0;
    flag_c_o   = 1'b0;
    unique case (op_i)
      OP_ADD: begin
        result_c_o = sum[OP_W-1:0];
        flag_c_o   = sum[OP_W];
`ifdef CALC_SAT_EN
        if (sum[OP_W]) result_c_o = '1;
`endif
      end
      OP_SUB: begin
        result_c_o = diff[OP_W-1:0];
        flag_c_o   = diff[OP_W];
`ifdef CALC_SAT_EN
        if (diff[OP_W]) result_c_o = '0;
`endif
      end
      OP_AND: result_c_o = a_i & b_i;
      OP_XOR: result_c_o = a_i ^ b_i;
      default: result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/calc_stream_controller.sv
// Streams source words [read_start_addr..read_end_addr] through calc_alu and
// packs LANES results per destination word starting at write_start_addr.
// Optional feature: CALC_SAT_EN (saturating ADD/SUB inside calc_alu).
// Ports:
//   clk_i, rst_i            : clock, synchronous active-low reset
//   start_i, op_i           : job start (sampled in S_IDLE) and operation
//   read_start_addr,
//   read_end_addr,
//   write_start_addr        : job address range, latched at start
//   read_o, r_addr_o        : read strobe/address
//   r_data_i                : read data, valid RD_LAT cycles after read_o
//   write_o, w_addr_o,
//   w_data_o                : write strobe/address/data
//   busy_o, done_o          : job in progress, one-cycle completion pulse
//   err_o, ovf_o            : range error (held), sticky carry/borrow
module calc_stream_controller
  import calculator_pkg::*;
#(
  parameter int unsigned OP_W   = DEF_OP_W,
  parameter int unsigned MEM_W  = DEF_MEM_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] read_start_addr,
  input  logic [ADDR_W-1:0] read_end_addr,
  input  logic [ADDR_W-1:0] write_start_addr,
  output logic              read_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [MEM_W-1:0]  r_data_i,
  output logic              write_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [MEM_W-1:0]  w_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_o
);

  localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WAIT_W    = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam int unsigned WAIT_INIT = (RD_LAT > 1) ? (RD_LAT - 2) : 0;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t              state_q;
  op_t                 op_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [ADDR_W-1:0]   rd_end_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [MEM_W-1:0]    pack_q;
  logic [MEM_W-1:0]    pack_d;
  logic [ADDR_W-1:0]   rd_ptr_inc;

  logic                read_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                write_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [MEM_W-1:0]    w_data_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                ovf_q;

  logic [OP_W-1:0]     alu_a;
  logic [OP_W-1:0]     alu_b;
  logic [OP_W-1:0]     alu_res;
  logic                alu_flag;

  // Low half is operand a, high half operand b
  assign alu_a = r_data_i[OP_W-1:0];
  assign alu_b = r_data_i[2*OP_W-1:OP_W];

  calc_alu #(
    .OP_W (OP_W)
  ) u_alu (
    .a_i        (alu_a),
    .b_i        (alu_b),
    .op_i       (op_q),
    .result_c_o (alu_res),
    .flag_c_o   (alu_flag)
  );

  assign rd_ptr_inc = rd_ptr_q + ADDR_W'(1);

  // Pack buffer with the current ALU result merged into the active lane
  always_comb begin
    pack_d = pack_q;
    pack_d[int'(lane_q)*OP_W +: OP_W] = alu_res;
  end

  // Controller FSM; all outputs are registered and strobes default low
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      rd_ptr_q   <= '0;
      rd_end_q   <= '0;
      wr_ptr_q   <= '0;
      lane_q     <= '0;
      wait_cnt_q <= '0;
      pack_q     <= '0;
      read_q     <= 1'b0;
      r_addr_q   <= '0;
      write_q    <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      read_q   <= 1'b0;
      r_addr_q <= '0;
      write_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      done_q   <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q     <= op_t'(op_i);
            rd_ptr_q <= read_start_addr;
            rd_end_q <= read_end_addr;
            wr_ptr_q <= write_start_addr;
            ovf_q    <= 1'b0;
            pack_q   <= '0;
            lane_q   <= '0;
            busy_q   <= 1'b1;
            if (read_end_addr < read_start_addr) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q    <= 1'b0;
              read_q   <= 1'b1;
              r_addr_q <= read_start_addr;
              state_q  <= S_READ;
            end
          end
        end

        S_READ: begin
          if (RD_LAT > 1) begin
            wait_cnt_q <= WAIT_W'(WAIT_INIT);
            state_q    <= S_WAIT;
          end else begin
            state_q <= S_EXEC;
          end
        end

        S_WAIT: begin
          if (wait_cnt_q == '0) state_q <= S_EXEC;
          else                  wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
        end

        S_EXEC: begin
          if (alu_flag) ovf_q <= 1'b1;
          if ((rd_ptr_q == rd_end_q) || (lane_q == LAST_LANE)) begin
            // Emit the packed word; the buffer restarts empty
            write_q  <= 1'b1;
            w_addr_q <= wr_ptr_q;
            w_data_q <= pack_d;
            pack_q   <= '0;
            lane_q   <= '0;
            state_q  <= S_WRITE;
          end else begin
            pack_q   <= pack_d;
            lane_q   <= lane_q + LANE_W'(1);
            rd_ptr_q <= rd_ptr_inc;
            read_q   <= 1'b1;
            r_addr_q <= rd_ptr_inc;
            state_q  <= S_READ;
          end
        end

        S_WRITE: begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (rd_ptr_q == rd_end_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rd_ptr_q <= rd_ptr_inc;
            read_q   <= 1'b1;
            r_addr_q <= rd_ptr_inc;
            state_q  <= S_READ;
          end
        end

        S_DONE: begin
          // Normal jobs arrive with done already raised; the range-error
          // path arrives with it low and raises it one cycle later.
          if (done_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_o   = read_q;
  assign r_addr_o = r_addr_q;
  assign write_o  = write_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign ovf_o    = ovf_q;

endmodule
